// File: rtl/pipe_pkg.sv
// Shared stage-bundle definitions for the core pipeline registers.
// EXMEM_W is the default payload width of pipe_stage_elastic.
package pipe_pkg;

    localparam int DEXT_W = 3;
    localparam int RD_W   = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_bundle_t;

    typedef struct packed {
        logic [DEXT_W-1:0] dext;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
    } idex_bundle_t;

    typedef struct packed {
        logic [DEXT_W-1:0] dext;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   csr_rdata;
    } exmem_bundle_t;

    typedef struct packed {
        logic [DEXT_W-1:0] dext;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   wb_data;
    } memwb_bundle_t;

    localparam int IFID_W  = $bits(ifid_bundle_t);
    localparam int IDEX_W  = $bits(idex_bundle_t);
    localparam int EXMEM_W = $bits(exmem_bundle_t);
    localparam int MEMWB_W = $bits(memwb_bundle_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {CNT_W{1'b1}}))
            value_d = value_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W     = EXMEM_W,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              accept;

    assign accept = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // Readiness depends only on skid occupancy, never on out_ready.
    assign in_ready = !skid_valid_q && !flush && !reset;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_DATA) out_data_d = '0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = (!out_valid_q || out_ready) && !flush && !reset;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            if (CLEAR_DATA) out_data_d = '0;
        end else if (accept) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (out_valid_q && !out_ready && !flush),
        .value (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic (3-bit stall counter, CLEAR_DATA=1).
// Follows PIPE_STAGE_SKID_EN when it is defined for the build.
module tb_pipe_stage_elastic;

    localparam int DW      = 168;
    localparam int CW      = 3;
    localparam int CNT_MAX = 7;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_elastic #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference: an ordered queue of held beats, capacity 1 (or 2 with skid).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last  = '0;
    int            m_cnt   = 0;
    bit            started = 1'b0;

    always @(negedge clk) begin
        bit m_rdy, acc, pop, m_vld;
        m_vld = (mq.size() > 0);
        m_rdy = !reset && !flush && (SKID ? (mq.size() < 2) : (!m_vld || out_ready));
        if (started) begin
            chk("m_out_valid", DW'(out_valid), DW'(m_vld));
            chk("m_out_data",  out_data,       m_last);
            chk("m_stall_cnt", DW'(stall_cnt), DW'(m_cnt));
            chk("m_in_ready",  DW'(in_ready),  DW'(m_rdy));
        end
        // advance to the state after the coming rising edge
        acc = in_valid && m_rdy;
        pop = m_vld && out_ready;
        if (reset) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else if (flush) begin
            mq.delete();
            m_last = '0;
        end else begin
            if (m_vld && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) m_last = mq[0];
        end
        started = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] vpat, rpat;
        vpat = 24'b1101_1110_0111_1011_0110_1111;
        rpat = 24'b0110_1011_1100_0101_1110_0011;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

        // reset, then idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data",  out_data,       '0);
        chk("rst_stall_cnt", DW'(stall_cnt), '0);
        chk("rst_in_ready",  DW'(in_ready),  DW'(1));

        // streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            tick(); in_valid = 1'b1; in_data = DW'(i);
            @(negedge clk);
            if (i > 1) chk("stream_data", out_data, DW'(i - 1));
        end
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last",  out_data,       DW'(8));
        chk("stream_stall", DW'(stall_cnt), '0);

        // backpressure: A5 held, B6 offered behind it
        tick(); in_valid = 1'b1; in_data = DW'(8'hA5); out_ready = 1'b0;
        tick(); in_data = DW'(8'hB6);
        @(negedge clk);
        chk("bp_hold_data",  out_data,       DW'(8'hA5));
        chk("bp_hold_valid", DW'(out_valid), DW'(1));
        repeat (3) tick();
        @(negedge clk);
        chk("bp_in_ready", DW'(in_ready),  '0);
        chk("bp_stall3",   DW'(stall_cnt), DW'(3));
        tick(); out_ready = 1'b1;
        @(negedge clk);
        chk("bp_stall4",  DW'(stall_cnt), DW'(4));
        chk("bp_first",   out_data,       DW'(8'hA5));
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second",  out_data,       DW'(8'hB6));
        chk("bp_sec_vld", DW'(out_valid), DW'(1));
        tick();
        @(negedge clk);
        chk("bp_drained", DW'(out_valid), '0);

        // flush while holding 55, with 66 offered in the flush cycle
        tick(); in_valid = 1'b1; in_data = DW'(8'h55); out_ready = 1'b0;
        tick(); in_data = DW'(8'h66); flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", DW'(in_ready), '0);
        tick(); flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", DW'(out_valid), '0);
        chk("fl_data",  out_data,       '0);
        chk("fl_stall", DW'(stall_cnt), DW'(4));
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("fl_after", out_data,       DW'(8'h66));
        chk("fl_avld",  DW'(out_valid), DW'(1));

        // long stall saturates the counter, then reset mid-stall
        tick(); in_valid = 1'b1; in_data = DW'(8'h77); out_ready = 1'b0;
        tick(); in_valid = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("sat_cnt",  DW'(stall_cnt), DW'(CNT_MAX));
        chk("sat_data", out_data,       DW'(8'h77));
        tick(); reset = 1'b1;
        @(negedge clk);
        chk("rst2_in_ready", DW'(in_ready), '0);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("rst2_valid", DW'(out_valid), '0);
        chk("rst2_data",  out_data,       '0);
        chk("rst2_cnt",   DW'(stall_cnt), '0);

        // mixed valid/ready pattern with a flush in the middle
        for (int i = 0; i < 24; i++) begin
            tick();
            in_valid  = vpat[i];
            out_ready = rpat[i];
            flush     = (i == 13);
            in_data   = DW'(32'h100 + i);
        end
        tick(); in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (3) tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic pipeline stage register. It generalises the fixed EX->MEM register to any payload width and adds:
- valid/ready handshake
- flush (bubble insertion)
- reset value control
- saturating backpressure counter
It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying a packed stage bundle.

Parameters:
DATA_W, 168, payload width in bits (default = EX->MEM bundle: 3+5+5*32).
CLEAR_DATA, 1, 1: flush also zeroes out_data; 0: flush clears only out_valid, data holds.
CNT_W, 16, width of stall_cnt.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of all held beats (branch mispredict / trap)
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream beat present
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  registered payload
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Interface rule (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset (reset=1 at edge) has priority over everything. Next cycle: out_valid=0, out_data=0, stall_cnt=0, skid entry empty. in_ready=0 while reset is high.
- Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge.
- Latency: accepted beat appears on out_data/out_valid the cycle after acceptance (1 cycle). Beats are never reordered, duplicated or dropped, except by flush.
- Base mode (single entry, macro undefined):
  - in_ready = !out_valid | out_ready (combinational from out_ready).
  - Accept: out_data<=in_data, out_valid<=1.
  - Transfer out without accept: out_valid<=0.
  - Otherwise hold.
  - Full throughput: accept and transfer out can occur in the same cycle.
- Flush (flush=1, reset=0):
  - in_ready forced 0, so no accept; an upstream beat presented that cycle is not consumed.
  - Next cycle: out_valid=0 and skid empty; out_data=0 if CLEAR_DATA=1, else out_data holds.
  - A downstream transfer in the flush cycle still completes as a handshake, but the stage is empty afterwards.
- out_valid and out_data are held stable while out_valid=1 and out_ready=0. in_valid may drop without penalty.
- stall_cnt:
  - Increments on every edge where out_valid=1, out_ready=0 and neither reset nor flush is asserted.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset.
- Widths: out_data is exactly DATA_W; no sign/zero extension inside the block.

Optional Feature:
Macro PIPE_STAGE_SKID_EN.
- Defined: adds a second (skid) entry; in_ready = !skid_valid, driven from a register only, so there is no combinational out_ready->in_ready path.
  - Accept while out_valid & !out_ready: beat goes to skid.
  - When out_ready and skid full: skid moves to main and skid empties. Order is preserved.
  - Full throughput, 1-cycle latency; flush clears both entries.
- Undefined: single-entry base mode as above.

Decomposition:
- Shared package pipe_pkg:
  - EX/MEM field widths (DEXT_W=3, RD_W=5, XLEN=32).
  - Packed struct typedef exmem_bundle_t and EXMEM_W constant for DATA_W.
  - Equivalent bundles for the other stages.
- One natural sub-module: sat_counter (CNT_W parameter, inc, clear, value, saturating), used for stall_cnt.

Test Plan:
1. Reset hold 3 cycles, then release with in_valid=0 -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
2. Stream in_data=1..8, in_valid=1, out_ready=1 -> out_data 1..8 in order, one per cycle, each 1 cycle after accept; stall_cnt stays 0.
3. Load 0xA5, hold out_ready=0 for 4 cycles -> out_data stays 0xA5, out_valid=1, stall_cnt=4. Base mode: in_ready=0. Skid mode: one extra beat 0xB6 accepted, then in_ready=0; after out_ready=1, output is 0xA5 then 0xB6.
4. Hold beat 0x55 with out_ready=0, assert flush 1 cycle with in_valid=1 carrying 0x66 -> next cycle out_valid=0, out_data=0 (CLEAR_DATA=1), 0x66 not accepted and is delivered after flush drops.
5. Set CNT_W=3, hold stall 10 cycles -> stall_cnt sticks at 7; assert reset mid-stall -> all outputs return to reset values next cycle.
